baud_rate_gen: RTL and testbench
================================

# baud_rate_gen

Parametrised two-channel baud tick generator for the UART. It replaces the single-divisor generator. It produces an oversample-rate `rx_tick` for the receiver and a bit-rate `tx_tick` for the transmitter from independent dividers that share one programmed divisor. Compared with its predecessor it adds:
- a fractional divisor;
- glitch-free staged divisor updates that never stall counting;
- per-channel enables;
- receiver phase resync.

## Interface
- `DIV_WIDTH`, default 16: integer divisor width (two byte-wide halves; 9..16 supported).
- `FRAC_BITS`, default 4: fractional divisor width (0 disables fractional logic).
- `OVERSAMPLE`, default 16: oversample ticks per bit; power of two, 2..64.
- `RESET_DIV`, default 326: divisor value after reset (50 MHz, 9600 bps, 16x).
- `clk` in, 1: clock.
- `rst_n` in, 1: reset, asynchronous, active-low.
- `cfg_we` in, 1: configuration write strobe, single cycle.
- `cfg_addr` in, 2: register select. 0 = DB_LO, 1 = DB_HI, 2 = FRAC, 3 = CTRL.
- `cfg_wdata` in, 8: write data.
- `cfg_rdata` out, 8: combinational read of the register selected by `cfg_addr`. DB_LO and DB_HI return the active divisor.
- `rx_resync` in, 1: restart RX channel phase. Pulsed by the receiver on start-bit detection.
- `rx_tick` out, 1: one-cycle pulse at the oversample rate.
- `tx_tick` out, 1: one-cycle pulse at the bit rate.

## Operation
- Registers:
  - Active divisor `D` (DIV_WIDTH).
  - Shadow low byte.
  - Fraction `F` (FRAC_BITS, stored in `cfg_wdata[FRAC_BITS-1:0]`).
  - CTRL: bit0 `tx_en`, bit1 `rx_en`. Reset value 0x03.
- Divisor writes:
  - A DB_LO write loads the shadow only.
  - A DB_HI write commits `{wdata, shadow}` (truncated to DIV_WIDTH) into `D` atomically.
  - FRAC writes commit directly.
  - Writes never pause counting. Each channel picks up the new `D` and `F` at its next reload, so an in-flight period always completes with old values.
- Each channel has:
  - a down-counter `cnt`;
  - a FRAC_BITS accumulator `acc`;
  - a `stretch` flag.
- Channel period rules:
  - When `cnt == 0` and not held: emit an oversample tick and reload `cnt` with `D + stretch_next`.
  - `{carry, acc} = acc + F` is evaluated at each tick, and `stretch_next = carry`.
  - Result: the period is D+1 cycles, lengthened to D+2 on F out of every 2^FRAC_BITS ticks.
  - Otherwise `cnt` decrements.
- RX channel:
  - `rx_tick` is its oversample tick.
  - `rx_resync` (priority over everything except reset) loads `cnt = D`, clears `acc` and stretch, and suppresses any tick that cycle.
- TX channel:
  - Has a postscaler `ps` (log2 OVERSAMPLE bits) incremented on each oversample tick.
  - `tx_tick` is asserted when `ps` wraps from OVERSAMPLE-1 to 0.
  - `rx_resync` has no effect on TX.
- Enable low on a channel holds that channel in its load state: `cnt = D`, `acc = 0`, `ps = 0`, tick output 0.
- D = 0, F = 0 gives `rx_tick` every cycle. F is ignored when FRAC_BITS = 0.
- Reset values:
  - `D = RESET_DIV`, shadow = 0, `F = 0`, CTRL = 0x03.
  - `cnt = RESET_DIV`, `acc = 0`, `ps = 0`.
  - `rx_tick = 0`, `tx_tick = 0`.
- Reset mid-operation discards all phase and any uncommitted shadow byte.

## Timing
- Tick outputs are registered: a pulse is high for exactly one cycle, in the cycle after the counter reads 0.
- Enable or resync at edge N gives the first tick at edge N+D+1 (F = 0). First `tx_tick` comes at N+OVERSAMPLE·(D+1).
- After reset release, first `rx_tick` comes RESET_DIV+1 cycles later. First `tx_tick` comes 16·327 = 5232 cycles later.
- A DB_HI write at edge N updates `cfg_rdata` from N+1. The counter uses it from the next reload.
- A write, `rx_resync` and a tick in the same cycle: resync wins for RX, and the write still commits.

## Structure
- Package `uart_pkg`:
  - CTRL bit indices;
  - `cfg_addr` encodings;
  - default RESET_DIV constant.
- Sub-module `baud_div_chan`, instantiated twice:
  - parameters `DIV_WIDTH`, `FRAC_BITS`, `POST` (1 for RX, OVERSAMPLE for TX);
  - ports `clk`, `rst_n`, `en`, `sync`, `div`, `frac`, `tick`.
- The top holds the register file, commit logic and read mux.

## Test plan
- Reset, defaults: `rx_tick` period 327 cycles; `tx_tick` period 5232; `cfg_rdata` at addr 0/1 = 0x46/0x01.
- DB_LO = 0x51 then DB_HI = 0x00 mid-period: current period stays 327, following periods 82, `tx_tick` every 1312.
- D = 9, F = 8, FRAC_BITS = 4: `rx_tick` intervals alternate 10/11; 16 ticks span exactly 168 cycles.
- `rx_resync` 100 cycles into a 327 period: next `rx_tick` exactly 327 cycles after resync; `tx_tick` timing unchanged.
- CTRL = 0x02 for 10000 cycles: no `tx_tick`. Then CTRL = 0x03: first `tx_tick` after 16·(D+1) cycles.
- Write DB_LO only, then assert `rst_n` low mid-period: ticks stop immediately, D returns to 326, the shadow byte is lost.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the UART baud generator.
//   - CTRL register bit positions and reset value
//   - cfg_addr register-select encodings
//   - default reset divisor (50 MHz clock, 9600 bps, 16x oversample)
package uart_pkg;

  localparam int CTRL_TX_EN = 0;
  localparam int CTRL_RX_EN = 1;
  localparam logic [1:0] CTRL_RESET = 2'b11;

  localparam int DEFAULT_RESET_DIV = 326;

  typedef enum logic [1:0] {
    ADDR_DB_LO = 2'd0,
    ADDR_DB_HI = 2'd1,
    ADDR_FRAC  = 2'd2,
    ADDR_CTRL  = 2'd3
  } cfg_addr_e;

endpackage

// File: rtl/baud_div_chan.sv
// baud_div_chan: one fractional tick divider channel with optional postscaler.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : channel enable; low holds the channel in its load state
//   sync       : phase restart; reloads the counter and clears the fraction
//   div        : active integer divisor (period is div+1 cycles)
//   frac       : active fractional divisor (extra cycle on frac of 2^FRAC_BITS ticks)
//   tick       : registered one-cycle pulse every POST oversample periods
module baud_div_chan #(
  parameter int DIV_WIDTH = 16,
  parameter int FRAC_BITS = 4,
  parameter int POST      = 1,
  parameter int RESET_DIV = 326,
  localparam int FW       = (FRAC_BITS > 0) ? FRAC_BITS : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 sync,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [FW-1:0]        frac,
  output logic                 tick
);

  // One extra bit so div + stretch cannot overflow at the maximum divisor.
  localparam int CW = DIV_WIDTH + 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] reload;
  logic          load;
  logic          os_tick;
  logic          stretch;

  assign load    = !en || sync;
  assign os_tick = !load && (cnt == '0);
  // The fraction accumulated at this tick decides the length of the next period.
  assign reload  = {1'b0, div} + CW'(stretch);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= CW'(RESET_DIV);
    end else if (load) begin
      cnt <= {1'b0, div};
    end else if (cnt == '0) begin
      cnt <= reload;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  generate
    if (FRAC_BITS > 0) begin : g_frac
      logic [FRAC_BITS-1:0] acc;
      logic [FRAC_BITS:0]   sum;

      assign sum     = {1'b0, acc} + {1'b0, frac};
      assign stretch = sum[FRAC_BITS];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc <= '0;
        end else if (load) begin
          acc <= '0;
        end else if (os_tick) begin
          acc <= sum[FRAC_BITS-1:0];
        end
      end
    end else begin : g_nofrac
      assign stretch = 1'b0;
    end
  endgenerate

  generate
    if (POST > 1) begin : g_post
      localparam int PS_W = $clog2(POST);
      logic [PS_W-1:0] ps;

      // POST is a power of two, so ps wraps to 0 naturally after POST-1.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ps   <= '0;
          tick <= 1'b0;
        end else if (!en) begin
          ps   <= '0;
          tick <= 1'b0;
        end else begin
          tick <= os_tick && (ps == PS_W'(POST - 1));
          if (os_tick) ps <= ps + 1'b1;
        end
      end
    end else begin : g_direct
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick <= 1'b0;
        else        tick <= os_tick;
      end
    end
  endgenerate

endmodule

// File: rtl/baud_rate_gen.sv
// baud_rate_gen: two-channel UART baud tick generator with fractional divisor.
//   clk, rst_n : clock, asynchronous active-low reset
//   cfg_we     : single-cycle register write strobe
//   cfg_addr   : register select (DB_LO, DB_HI, FRAC, CTRL)
//   cfg_wdata  : register write data
//   cfg_rdata  : combinational read of the selected register; DB_LO/DB_HI
//                return the active divisor, not the shadow byte
//   rx_resync  : restart RX phase (start-bit detected)
//   rx_tick    : oversample-rate pulse for the receiver
//   tx_tick    : bit-rate pulse for the transmitter
module baud_rate_gen
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH  = 16,
  parameter int FRAC_BITS  = 4,
  parameter int OVERSAMPLE = 16,
  parameter int RESET_DIV  = DEFAULT_RESET_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  output logic [7:0] cfg_rdata,
  input  logic       rx_resync,
  output logic       rx_tick,
  output logic       tx_tick
);

  localparam int FW = (FRAC_BITS > 0) ? FRAC_BITS : 1;

  logic [DIV_WIDTH-1:0] div_q;
  logic [7:0]           shadow;
  logic [FW-1:0]        frac_q;
  logic [1:0]           ctrl;
  logic [15:0]          commit_val;
  logic [15:0]          div_ext;

  // The high-byte write carries the whole divisor in one edge, so the
  // channels never see a half-updated value.
  assign commit_val = {cfg_wdata, shadow};
  assign div_ext    = 16'(div_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= DIV_WIDTH'(RESET_DIV);
      shadow <= '0;
      frac_q <= '0;
      ctrl   <= CTRL_RESET;
    end else if (cfg_we) begin
      case (cfg_addr_e'(cfg_addr))
        ADDR_DB_LO: shadow <= cfg_wdata;
        ADDR_DB_HI: div_q  <= commit_val[DIV_WIDTH-1:0];
        ADDR_FRAC:  if (FRAC_BITS > 0) frac_q <= cfg_wdata[FW-1:0];
        ADDR_CTRL:  ctrl   <= cfg_wdata[1:0];
      endcase
    end
  end

  // NOTE: the default assignment first keeps this block purely combinational;
  // without it any unlisted path would hold the old value and infer a latch.
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr_e'(cfg_addr))
      ADDR_DB_LO: cfg_rdata = div_ext[7:0];
      ADDR_DB_HI: cfg_rdata = div_ext[15:8];
      ADDR_FRAC:  cfg_rdata = 8'(frac_q);
      ADDR_CTRL:  cfg_rdata = {6'b0, ctrl};
    endcase
  end

  baud_div_chan #(
    .DIV_WIDTH (DIV_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .POST      (1),
    .RESET_DIV (RESET_DIV)
  ) u_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ctrl[CTRL_RX_EN]),
    .sync  (rx_resync),
    .div   (div_q),
    .frac  (frac_q),
    .tick  (rx_tick)
  );

  // The transmitter never resynchronises; its phase only restarts on enable.
  baud_div_chan #(
    .DIV_WIDTH (DIV_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .POST      (OVERSAMPLE),
    .RESET_DIV (RESET_DIV)
  ) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ctrl[CTRL_TX_EN]),
    .sync  (1'b0),
    .div   (div_q),
    .frac  (frac_q),
    .tick  (tx_tick)
  );

endmodule

// File: tb/tb_baud_rate_gen.sv
// tb_baud_rate_gen: scoreboard bench for baud_rate_gen.
// Tick edges are time-stamped by a monitor; each scenario pushes expected
// values as it drives stimulus and compares them against observations.
module tb_baud_rate_gen;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = 2'd0;
  logic [7:0] cfg_wdata = 8'd0;
  logic [7:0] cfg_rdata;
  logic       rx_resync = 1'b0;
  logic       rx_tick;
  logic       tx_tick;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          rx_times[$];
  int          tx_times[$];
  int          exp_q[$];
  logic [31:0] obs_q[$];
  string       name_q[$];

  baud_rate_gen #(
    .DIV_WIDTH  (16),
    .FRAC_BITS  (4),
    .OVERSAMPLE (16),
    .RESET_DIV  (326)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .rx_resync (rx_resync),
    .rx_tick   (rx_tick),
    .tx_tick   (tx_tick)
  );

  always #5 clk = ~clk;

  // cyc holds the index of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rx_tick) rx_times.push_back(cyc);
    if (tx_tick) tx_times.push_back(cyc);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    cfg_addr = a;
    #1;
    v = cfg_rdata;
  endtask

  task automatic pulse_resync;
    rx_resync = 1'b1;
    @(negedge clk);
    rx_resync = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_times.size() < n && k < budget) begin @(negedge clk); k++; end
    if (rx_times.size() < n) begin
      errors++;
      $display("FAIL wait_rx: saw %0d rx ticks, required %0d", rx_times.size(), n);
    end
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k = 0;
    while (tx_times.size() < n && k < budget) begin @(negedge clk); k++; end
    if (tx_times.size() < n) begin
      errors++;
      $display("FAIL wait_tx: saw %0d tx ticks, required %0d", tx_times.size(), n);
    end
  endtask

  task automatic test_reset;
    logic [7:0] v;
    int rel, e;
    logic [31:0] o;
    string nm;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.push_back(0); obs_q.push_back(32'(rx_tick)); name_q.push_back("rst_rx_tick");
    exp_q.push_back(0); obs_q.push_back(32'(tx_tick)); name_q.push_back("rst_tx_tick");
    rd(ADDR_DB_LO, v); exp_q.push_back(8'h46); obs_q.push_back(32'(v)); name_q.push_back("rst_db_lo");
    rd(ADDR_DB_HI, v); exp_q.push_back(8'h01); obs_q.push_back(32'(v)); name_q.push_back("rst_db_hi");
    rd(ADDR_FRAC, v);  exp_q.push_back(8'h00); obs_q.push_back(32'(v)); name_q.push_back("rst_frac");
    rd(ADDR_CTRL, v);  exp_q.push_back(8'h03); obs_q.push_back(32'(v)); name_q.push_back("rst_ctrl");
    @(negedge clk);
    rel = cyc;
    rst_n = 1'b1;
    exp_q.push_back(rel + 327);   name_q.push_back("rst_rx_first");
    exp_q.push_back(rel + 654);   name_q.push_back("rst_rx_second");
    exp_q.push_back(rel + 5232);  name_q.push_back("rst_tx_first");
    exp_q.push_back(rel + 10464); name_q.push_back("rst_tx_second");
    wait_tx(2, 11000);
    obs_q.push_back(32'(rx_times[0]));
    obs_q.push_back(32'(rx_times[1]));
    obs_q.push_back(32'(tx_times[0]));
    obs_q.push_back(32'(tx_times[1]));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (o !== 32'(e)) begin errors++; $display("FAIL %s: observed %0d expected %0d", nm, o, e); end
    end
  endtask

  task automatic test_div_update;
    logic [7:0] v;
    int s, t, k, e;
    logic [31:0] o;
    string nm;
    s = rx_times.size();
    wait_rx(s + 1, 400);
    t = rx_times[s];
    repeat (50) @(negedge clk);
    cfg_write(ADDR_DB_LO, 8'h51);
    rd(ADDR_DB_LO, v); exp_q.push_back(8'h46); obs_q.push_back(32'(v)); name_q.push_back("upd_lo_before_commit");
    cfg_write(ADDR_DB_HI, 8'h00);
    rd(ADDR_DB_LO, v); exp_q.push_back(8'h51); obs_q.push_back(32'(v)); name_q.push_back("upd_lo_after_commit");
    rd(ADDR_DB_HI, v); exp_q.push_back(8'h00); obs_q.push_back(32'(v)); name_q.push_back("upd_hi_after_commit");
    exp_q.push_back(t + 327); name_q.push_back("upd_rx_inflight");
    exp_q.push_back(t + 409); name_q.push_back("upd_rx_new1");
    exp_q.push_back(t + 491); name_q.push_back("upd_rx_new2");
    wait_rx(s + 4, 800);
    obs_q.push_back(32'(rx_times[s + 1]));
    obs_q.push_back(32'(rx_times[s + 2]));
    obs_q.push_back(32'(rx_times[s + 3]));
    k = tx_times.size();
    exp_q.push_back(1312); name_q.push_back("upd_tx_period");
    wait_tx(k + 3, 10000);
    obs_q.push_back(32'(tx_times[k + 2] - tx_times[k + 1]));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (o !== 32'(e)) begin errors++; $display("FAIL %s: observed %0d expected %0d", nm, o, e); end
    end
  endtask

  task automatic test_frac;
    logic [7:0] v;
    int s, rs, e;
    logic [31:0] o;
    string nm;
    cfg_write(ADDR_DB_LO, 8'd9);
    cfg_write(ADDR_DB_HI, 8'd0);
    cfg_write(ADDR_FRAC, 8'd8);
    rd(ADDR_FRAC, v); exp_q.push_back(8); obs_q.push_back(32'(v)); name_q.push_back("frac_readback");
    s = rx_times.size();
    rs = cyc;
    pulse_resync();
    exp_q.push_back(rs + 11); name_q.push_back("frac_first_after_resync");
    // From a cleared accumulator with F = 8 the intervals run 10, 11, 10, 11, ...
    for (int i = 1; i <= 16; i++) begin
      exp_q.push_back((i % 2 == 0) ? 11 : 10);
      name_q.push_back($sformatf("frac_interval_%0d", i));
    end
    exp_q.push_back(168); name_q.push_back("frac_span16");
    wait_rx(s + 18, 400);
    obs_q.push_back(32'(rx_times[s]));
    for (int i = 1; i <= 16; i++) obs_q.push_back(32'(rx_times[s + i] - rx_times[s + i - 1]));
    obs_q.push_back(32'(rx_times[s + 17] - rx_times[s + 1]));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (o !== 32'(e)) begin errors++; $display("FAIL %s: observed %0d expected %0d", nm, o, e); end
    end
    cfg_write(ADDR_FRAC, 8'd0);
    cfg_write(ADDR_DB_LO, 8'h46);
    cfg_write(ADDR_DB_HI, 8'h01);
  endtask

  task automatic test_resync;
    int k, s, t, rs, s2, e;
    logic [31:0] o;
    string nm;
    k = tx_times.size();
    wait_tx(k + 1, 6000);
    s = rx_times.size();
    wait_rx(s + 1, 400);
    t = rx_times[s];
    while (cyc < t + 100) @(negedge clk);
    rs = cyc;
    s2 = rx_times.size();
    pulse_resync();
    exp_q.push_back(rs + 328);         name_q.push_back("resync_rx_next");
    exp_q.push_back(tx_times[k] + 5232); name_q.push_back("resync_tx_unchanged");
    wait_rx(s2 + 1, 400);
    obs_q.push_back(32'(rx_times[s2]));
    wait_tx(k + 2, 6000);
    obs_q.push_back(32'(tx_times[k + 1]));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (o !== 32'(e)) begin errors++; $display("FAIL %s: observed %0d expected %0d", nm, o, e); end
    end
  endtask

  // Resync, a DB_HI write and a due tick all land on the same edge.
  task automatic test_collision;
    logic [7:0] v;
    int s, t, s2, e;
    logic [31:0] o;
    string nm;
    s = rx_times.size();
    wait_rx(s + 1, 400);
    t = rx_times[s];
    while (cyc < t + 326) @(negedge clk);
    s2 = rx_times.size();
    cfg_we = 1'b1; cfg_addr = ADDR_DB_HI; cfg_wdata = 8'h00; rx_resync = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; rx_resync = 1'b0;
    rd(ADDR_DB_HI, v); exp_q.push_back(8'h00); obs_q.push_back(32'(v)); name_q.push_back("coll_write_committed");
    // The suppressed tick at t+327 is replaced by one a full old period later,
    // then the new divisor 0x46 takes over.
    exp_q.push_back(t + 654); name_q.push_back("coll_rx_after_resync");
    exp_q.push_back(t + 725); name_q.push_back("coll_rx_new_div");
    wait_rx(s2 + 2, 800);
    obs_q.push_back(32'(rx_times[s2]));
    obs_q.push_back(32'(rx_times[s2 + 1]));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (o !== 32'(e)) begin errors++; $display("FAIL %s: observed %0d expected %0d", nm, o, e); end
    end
  endtask

  task automatic test_enable;
    logic [7:0] v;
    int k, r, n, cnt, e;
    logic [31:0] o;
    string nm;
    cfg_write(ADDR_CTRL, 8'h02);
    k = tx_times.size();
    r = rx_times.size();
    repeat (10000) @(negedge clk);
    exp_q.push_back(k); obs_q.push_back(32'(tx_times.size())); name_q.push_back("en_tx_held");
    cnt = rx_times.size() - r;
    exp_q.push_back(1); obs_q.push_back((cnt >= 139 && cnt <= 142) ? 32'd1 : 32'd0); name_q.push_back("en_rx_running");
    n = cyc;
    cfg_write(ADDR_CTRL, 8'h03);
    rd(ADDR_CTRL, v); exp_q.push_back(8'h03); obs_q.push_back(32'(v)); name_q.push_back("en_ctrl_readback");
    exp_q.push_back(n + 1 + 16 * 71); name_q.push_back("en_tx_first");
    wait_tx(k + 1, 1300);
    obs_q.push_back(32'(tx_times[k]));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (o !== 32'(e)) begin errors++; $display("FAIL %s: observed %0d expected %0d", nm, o, e); end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] v;
    int s, s2, s3, s4, rel, e;
    logic [31:0] o;
    string nm;
    cfg_write(ADDR_DB_LO, 8'h51);
    s = rx_times.size();
    wait_rx(s + 1, 100);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.push_back(0); obs_q.push_back(32'(rx_tick)); name_q.push_back("rmid_rx_low");
    exp_q.push_back(0); obs_q.push_back(32'(tx_tick)); name_q.push_back("rmid_tx_low");
    s2 = rx_times.size();
    repeat (50) @(negedge clk);
    exp_q.push_back(s2); obs_q.push_back(32'(rx_times.size())); name_q.push_back("rmid_no_ticks");
    rd(ADDR_DB_LO, v); exp_q.push_back(8'h46); obs_q.push_back(32'(v)); name_q.push_back("rmid_db_lo");
    rd(ADDR_DB_HI, v); exp_q.push_back(8'h01); obs_q.push_back(32'(v)); name_q.push_back("rmid_db_hi");
    @(negedge clk);
    rel = cyc;
    s3 = rx_times.size();
    rst_n = 1'b1;
    exp_q.push_back(rel + 327); name_q.push_back("rmid_rx_first");
    wait_rx(s3 + 1, 400);
    obs_q.push_back(32'(rx_times[s3]));
    // The 0x51 shadow byte was discarded, so this commits D = 0.
    cfg_write(ADDR_DB_HI, 8'h00);
    rd(ADDR_DB_LO, v); exp_q.push_back(8'h00); obs_q.push_back(32'(v)); name_q.push_back("rmid_shadow_lost");
    s4 = rx_times.size();
    wait_rx(s4 + 8, 400);
    for (int i = 2; i <= 7; i++) begin
      exp_q.push_back(1);
      obs_q.push_back(32'(rx_times[s4 + i] - rx_times[s4 + i - 1]));
      name_q.push_back($sformatf("rmid_d0_interval_%0d", i));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (o !== 32'(e)) begin errors++; $display("FAIL %s: observed %0d expected %0d", nm, o, e); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_div_update();
    test_frac();
    test_resync();
    test_collision();
    test_enable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
